// File: rtl/tx_retry_ctl.sv
// tx_retry_ctl: per-frame transmit retry/backoff controller.
// Tracks one frame through TX, ACK wait, timeout and retransmission, keeps the
// retry count and contention-window exponent, draws random backoff slots, and
// emits a single-cycle tx_try_complete pulse with the final status.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   max_retry[3:0]       retransmissions allowed after the first attempt
//   ack_timeout[15:0]    ACK wait length in clk cycles
//   tx_start, need_ack   new frame pulse and its ACK requirement
//   linux_prio_in, tx_queue_idx_in, tx_pkt_sn_in   metadata sampled with tx_start
//   tx_end, ack_ok       attempt finished / ACK received pulses
//   busy                 frame in flight (through the complete cycle)
//   retrans_req          retransmission request pulse
//   tx_try_complete      frame finished pulse
//   tx_status[4:0]       {fail, retry_cnt}
//   cw[3:0]              contention-window exponent
//   num_slot_random[9:0] last drawn backoff slot count
//   linux_prio, tx_queue_idx, tx_pkt_sn   latched metadata
module tx_retry_ctl #(
  parameter int unsigned CW_MIN_EXP = 4,
  parameter int unsigned CW_MAX_EXP = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  max_retry,
  input  logic [15:0] ack_timeout,
  input  logic        tx_start,
  input  logic        need_ack,
  input  logic [1:0]  linux_prio_in,
  input  logic [1:0]  tx_queue_idx_in,
  input  logic [9:0]  tx_pkt_sn_in,
  input  logic        tx_end,
  input  logic        ack_ok,
  output logic        busy,
  output logic        retrans_req,
  output logic        tx_try_complete,
  output logic [4:0]  tx_status,
  output logic [3:0]  cw,
  output logic [9:0]  num_slot_random,
  output logic [1:0]  linux_prio,
  output logic [1:0]  tx_queue_idx,
  output logic [9:0]  tx_pkt_sn
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned SLOT_W  = 10;
  localparam int unsigned SN_W    = 10;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TX       = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_lfsr;
  logic [15:0]         w_lfsr_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt;
  logic [CNT_W-1:0]    r_retry, w_retry_nxt;
  logic [3:0]          r_cw, w_cw_nxt, w_cw_inc;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic                r_need_ack, w_need_ack_nxt;
  logic [1:0]          r_prio, w_prio_nxt;
  logic [1:0]          r_qidx, w_qidx_nxt;
  logic [SN_W-1:0]     r_sn, w_sn_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_retrans, w_retrans_nxt;
  logic                r_complete, w_complete_nxt;
  logic [4:0]          r_status, w_status_nxt;

  // Backoff draw: low LFSR bits masked to 2^exp - 1
  function automatic logic [SLOT_W-1:0] draw(input logic [SLOT_W-1:0] rnd,
                                             input logic [3:0] exp);
    logic [SLOT_W:0] mask;
    mask = (11'd1 << exp) - 11'd1;
    return rnd & mask[SLOT_W-1:0];
  endfunction

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign w_cw_inc = (r_cw >= 4'(CW_MAX_EXP)) ? 4'(CW_MAX_EXP) : r_cw + 4'd1;

  // Registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_lfsr     <= 16'hACE1;
      r_timer    <= '0;
      r_retry    <= '0;
      r_cw       <= '0;
      r_slot     <= '0;
      r_need_ack <= 1'b0;
      r_prio     <= '0;
      r_qidx     <= '0;
      r_sn       <= '0;
      r_busy     <= 1'b0;
      r_retrans  <= 1'b0;
      r_complete <= 1'b0;
      r_status   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_timer    <= w_timer_nxt;
      r_retry    <= w_retry_nxt;
      r_cw       <= w_cw_nxt;
      r_slot     <= w_slot_nxt;
      r_need_ack <= w_need_ack_nxt;
      r_prio     <= w_prio_nxt;
      r_qidx     <= w_qidx_nxt;
      r_sn       <= w_sn_nxt;
      r_busy     <= w_busy_nxt;
      r_retrans  <= w_retrans_nxt;
      r_complete <= w_complete_nxt;
      r_status   <= w_status_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_retry_nxt    = r_retry;
    w_cw_nxt       = r_cw;
    w_slot_nxt     = r_slot;
    w_need_ack_nxt = r_need_ack;
    w_prio_nxt     = r_prio;
    w_qidx_nxt     = r_qidx;
    w_sn_nxt       = r_sn;
    w_retrans_nxt  = 1'b0;
    w_complete_nxt = 1'b0;
    w_status_nxt   = r_status;

    unique case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_need_ack_nxt = need_ack;
          w_prio_nxt     = linux_prio_in;
          w_qidx_nxt     = tx_queue_idx_in;
          w_sn_nxt       = tx_pkt_sn_in;
          w_retry_nxt    = '0;
          w_cw_nxt       = 4'(CW_MIN_EXP);
          w_slot_nxt     = draw(r_lfsr[SLOT_W-1:0], 4'(CW_MIN_EXP));
          w_state_nxt    = S_TX;
        end
      end
      S_TX: begin
        if (tx_end) begin
          if (r_need_ack) begin
            w_timer_nxt = ack_timeout;
            w_state_nxt = S_WAIT_ACK;
          end else begin
            w_complete_nxt = 1'b1;
            w_status_nxt   = {1'b0, r_retry};
            w_state_nxt    = S_IDLE;
          end
        end
      end
      S_WAIT_ACK: begin
        if (r_timer != '0) w_timer_nxt = r_timer - 16'd1;
        // ACK has priority over a simultaneous expiry
        if (ack_ok) begin
          w_complete_nxt = 1'b1;
          w_status_nxt   = {1'b0, r_retry};
          w_state_nxt    = S_IDLE;
        end else if (r_timer == '0) begin
          // >= keeps retry_cnt bounded even if max_retry drops mid-frame
          if (r_retry >= max_retry) begin
            w_complete_nxt = 1'b1;
            w_status_nxt   = {1'b1, r_retry};
            w_state_nxt    = S_IDLE;
          end else begin
            w_retry_nxt   = r_retry + 4'd1;
            w_cw_nxt      = w_cw_inc;
            w_slot_nxt    = draw(r_lfsr[SLOT_W-1:0], w_cw_inc);
            w_retrans_nxt = 1'b1;
            w_state_nxt   = S_TX;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // busy stays up through the complete cycle
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_complete_nxt;
  end

  assign busy            = r_busy;
  assign retrans_req     = r_retrans;
  assign tx_try_complete = r_complete;
  assign tx_status       = r_status;
  assign cw              = r_cw;
  assign num_slot_random = r_slot;
  assign linux_prio      = r_prio;
  assign tx_queue_idx    = r_qidx;
  assign tx_pkt_sn       = r_sn;

endmodule

// File: tb/tb_tx_retry_ctl.sv
// Self-checking bench for tx_retry_ctl: cycle table plus multi-cycle sequences.
module tb_tx_retry_ctl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  max_retry;
  logic [15:0] ack_timeout;
  logic        tx_start, need_ack, tx_end, ack_ok;
  logic [1:0]  linux_prio_in, tx_queue_idx_in;
  logic [9:0]  tx_pkt_sn_in;

  logic        busy, retrans_req, tx_try_complete;
  logic [4:0]  tx_status;
  logic [3:0]  cw;
  logic [9:0]  num_slot_random;
  logic [1:0]  linux_prio, tx_queue_idx;
  logic [9:0]  tx_pkt_sn;

  logic        busy_c, retrans_req_c, tx_try_complete_c;
  logic [4:0]  tx_status_c;
  logic [3:0]  cw_c;
  logic [9:0]  num_slot_random_c;
  logic [1:0]  linux_prio_c, tx_queue_idx_c;
  logic [9:0]  tx_pkt_sn_c;

  int n_vec = 0;
  int n_err = 0;
  int n_rr  = 0;
  int n_cmp = 0;

  logic [15:0] m_lfsr, m_prev;

  always #5 clk = ~clk;

  tx_retry_ctl dut (
    .clk(clk), .rstn(rstn), .max_retry(max_retry), .ack_timeout(ack_timeout),
    .tx_start(tx_start), .need_ack(need_ack), .linux_prio_in(linux_prio_in),
    .tx_queue_idx_in(tx_queue_idx_in), .tx_pkt_sn_in(tx_pkt_sn_in),
    .tx_end(tx_end), .ack_ok(ack_ok), .busy(busy), .retrans_req(retrans_req),
    .tx_try_complete(tx_try_complete), .tx_status(tx_status), .cw(cw),
    .num_slot_random(num_slot_random), .linux_prio(linux_prio),
    .tx_queue_idx(tx_queue_idx), .tx_pkt_sn(tx_pkt_sn)
  );

  tx_retry_ctl #(.CW_MIN_EXP(4), .CW_MAX_EXP(6)) dut_cap (
    .clk(clk), .rstn(rstn), .max_retry(max_retry), .ack_timeout(ack_timeout),
    .tx_start(tx_start), .need_ack(need_ack), .linux_prio_in(linux_prio_in),
    .tx_queue_idx_in(tx_queue_idx_in), .tx_pkt_sn_in(tx_pkt_sn_in),
    .tx_end(tx_end), .ack_ok(ack_ok), .busy(busy_c), .retrans_req(retrans_req_c),
    .tx_try_complete(tx_try_complete_c), .tx_status(tx_status_c), .cw(cw_c),
    .num_slot_random(num_slot_random_c), .linux_prio(linux_prio_c),
    .tx_queue_idx(tx_queue_idx_c), .tx_pkt_sn(tx_pkt_sn_c)
  );

  // Reference LFSR; m_prev is the value the DUT drew from at the last edge
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Pulse counters, sampled before the edge updates the outputs
  always @(posedge clk) begin
    if (retrans_req)     n_rr  <= n_rr + 1;
    if (tx_try_complete) n_cmp <= n_cmp + 1;
  end

  typedef struct {
    logic       rstn, start, need, tend, ack;
    logic [3:0] mr;
    logic       busy, rr, cmp;
    logic [4:0] st;
    logic [3:0] cw;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_frame(input logic na, input logic [9:0] sn);
    tx_start = 1'b1; need_ack = na; tx_pkt_sn_in = sn;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic pulse_end();
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for retrans_req or tx_try_complete; k = cycles waited
  task automatic wait_evt(input int budget, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(retrans_req || tx_try_complete) && k < budget);
    chk("event_seen", 32'(retrans_req | tx_try_complete), 32'd1);
  endtask

  function automatic logic [9:0] expect_slot(input logic [15:0] l, input int e);
    int m;
    m = (1 << e) - 1;
    return l[9:0] & 10'(m);
  endfunction

  initial begin
    int k, rr0, cmp0;
    logic [9:0] exp_slot;

    rstn = 1'b0; max_retry = 4'd1; ack_timeout = 16'd0;
    tx_start = 1'b0; need_ack = 1'b0; tx_end = 1'b0; ack_ok = 1'b0;
    linux_prio_in = 2'd3; tx_queue_idx_in = 2'd2; tx_pkt_sn_in = 10'h155;

    //                 rstn  st    need  end   ack   mr     busy  rr    cmp   status  cw
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'h00, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 5'h00, 4'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 5'h00, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h00, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 5'h01, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'h01, 4'd5});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h01, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h01, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 5'h01, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'h01, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 5'h11, 4'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 5'h11, 4'd5});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'h11, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'h11, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 5'h10, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h10, 4'd4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'h10, 4'd4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'h10, 4'd4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h00, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h00, 4'd0});

    // Cycle table with ack_timeout = 0: each row is one edge
    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; tx_start = tbl[i].start; need_ack = tbl[i].need;
      tx_end = tbl[i].tend; ack_ok = tbl[i].ack; max_retry = tbl[i].mr;
      tick();
      chk($sformatf("row%0d {busy,rr,cmp,status,cw}", i),
          32'({busy, retrans_req, tx_try_complete, tx_status, cw}),
          32'({tbl[i].busy, tbl[i].rr, tbl[i].cmp, tbl[i].st, tbl[i].cw}));
    end
    tx_start = 1'b0; tx_end = 1'b0; ack_ok = 1'b0;
    chk("reset_slot", 32'(num_slot_random), 32'd0);

    // Success on first try after reset, ACK 20 cycles after tx_end
    max_retry = 4'd3; ack_timeout = 16'd100;
    linux_prio_in = 2'd2; tx_queue_idx_in = 2'd1;
    rr0 = n_rr; cmp0 = n_cmp;
    start_frame(1'b1, 10'h2A5);
    exp_slot = expect_slot(m_prev, 4);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_cw", 32'(cw), 32'd4);
    chk("s1_slot", 32'(num_slot_random), 32'(exp_slot));
    chk("s1_meta", 32'({linux_prio, tx_queue_idx, tx_pkt_sn}), 32'({2'd2, 2'd1, 10'h2A5}));
    ticks(5);
    pulse_end();
    ticks(19);
    ack_ok = 1'b1;
    tick();
    ack_ok = 1'b0;
    chk("s1_complete", 32'(tx_try_complete), 32'd1);
    chk("s1_status", 32'(tx_status), 32'h00);
    chk("s1_cw_done", 32'(cw), 32'd4);
    tick();
    chk("s1_after", 32'({busy, tx_try_complete, tx_status}), 32'd0);
    chk("s1_hold", 32'({num_slot_random, tx_pkt_sn}), 32'({exp_slot, 10'h2A5}));
    chk("s1_pulses", 32'((n_rr - rr0) * 16 + (n_cmp - cmp0)), 32'd1);

    // Retry exhaustion: three retransmissions, cw 5,6,7, then fail
    max_retry = 4'd3; ack_timeout = 16'd10;
    rr0 = n_rr; cmp0 = n_cmp;
    start_frame(1'b1, 10'h0F0);
    for (int a = 0; a <= 3; a++) begin
      ticks(3);
      pulse_end();
      wait_evt(40, k);
      chk($sformatf("s3_latency%0d", a), 32'(k), 32'd11);
      if (a < 3) begin
        exp_slot = expect_slot(m_prev, 5 + a);
        chk($sformatf("s3_rr%0d", a), 32'({retrans_req, tx_try_complete}), 32'b10);
        chk($sformatf("s3_cw%0d", a), 32'(cw), 32'(5 + a));
        chk($sformatf("s3_slot%0d", a), 32'(num_slot_random), 32'(exp_slot));
        chk($sformatf("s3_slot_bound%0d", a), 32'(int'(num_slot_random) < (1 << (5 + a))), 32'd1);
      end else begin
        chk("s3_fail_cmp", 32'({retrans_req, tx_try_complete}), 32'b01);
        chk("s3_fail_status", 32'(tx_status), 32'h13);
        chk("s3_fail_cw", 32'(cw), 32'd7);
      end
    end
    tick();
    chk("s3_pulses", 32'((n_rr - rr0) * 16 + (n_cmp - cmp0)), 32'h31);
    chk("s3_idle", 32'(busy), 32'd0);

    // CW cap at 6 on the capped instance, ACK on the fifth attempt
    max_retry = 4'd5; ack_timeout = 16'd4;
    start_frame(1'b1, 10'h3C3);
    for (int a = 0; a < 4; a++) begin
      ticks(2);
      pulse_end();
      wait_evt(20, k);
      chk($sformatf("s4_latency%0d", a), 32'(k), 32'd5);
      chk($sformatf("s4_rr%0d", a), 32'({retrans_req_c, tx_try_complete_c}), 32'b10);
      chk($sformatf("s4_cwcap%0d", a), 32'(cw_c), 32'((5 + a > 6) ? 6 : 5 + a));
      chk($sformatf("s4_cw%0d", a), 32'(cw), 32'(5 + a));
      chk($sformatf("s4_slot_bound%0d", a), 32'(int'(num_slot_random_c) < 64), 32'd1);
    end
    ticks(2);
    pulse_end();
    tick();
    ack_ok = 1'b1;
    tick();
    ack_ok = 1'b0;
    chk("s4_cmp", 32'({tx_try_complete_c, tx_try_complete, retrans_req}), 32'b110);
    chk("s4_status_cap", 32'(tx_status_c), 32'h04);
    chk("s4_status", 32'(tx_status), 32'h04);
    chk("s4_cw_final", 32'({cw_c, cw}), 32'({4'd6, 4'd8}));
    tick();

    // Races: tx_start while busy ignored; ACK on the expiry edge wins
    max_retry = 4'd2; ack_timeout = 16'd5;
    rr0 = n_rr;
    start_frame(1'b1, 10'h111);
    tick();
    start_frame(1'b1, 10'h3FF);
    chk("s5_sn_kept", 32'(tx_pkt_sn), 32'h111);
    chk("s5_cw_kept", 32'({busy, cw}), 32'({1'b1, 4'd4}));
    pulse_end();
    ticks(5);
    chk("s5_no_early", 32'({retrans_req, tx_try_complete}), 32'd0);
    ack_ok = 1'b1;
    tick();
    ack_ok = 1'b0;
    chk("s5_ack_wins", 32'({retrans_req, tx_try_complete, tx_status}), 32'({1'b0, 1'b1, 5'h00}));
    tick();
    chk("s5_no_rr", 32'(n_rr - rr0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
